// File: rtl/cpu_csr_axi_if.sv
// AXI4 slave-side signal bundle for the CSR target. The address and ID fields both use ADDR_WIDTH.
// Every channel transfers on the rising edge where valid and ready are both 1. After raising valid,
// the source holds valid and its payload unchanged until that edge, and ready never gates valid.
interface cpu_csr_axi_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   s_axi_awaddr;
  logic [ADDR_WIDTH-1:0]   s_axi_awid;
  logic [7:0]              s_axi_awlen;
  logic [2:0]              s_axi_awsize;
  logic [1:0]              s_axi_awburst;
  logic                    s_axi_awvalid;
  logic                    s_axi_awready;
  logic [DATA_WIDTH-1:0]   s_axi_wdata;
  logic [DATA_WIDTH/8-1:0] s_axi_wstrb;
  logic                    s_axi_wlast;
  logic                    s_axi_wvalid;
  logic                    s_axi_wready;
  logic [ADDR_WIDTH-1:0]   s_axi_bid;
  logic [1:0]              s_axi_bresp;
  logic                    s_axi_bvalid;
  logic                    s_axi_bready;
  logic [ADDR_WIDTH-1:0]   s_axi_araddr;
  logic [ADDR_WIDTH-1:0]   s_axi_arid;
  logic [7:0]              s_axi_arlen;
  logic [2:0]              s_axi_arsize;
  logic [1:0]              s_axi_arburst;
  logic                    s_axi_arvalid;
  logic                    s_axi_arready;
  logic [DATA_WIDTH-1:0]   s_axi_rdata;
  logic [ADDR_WIDTH-1:0]   s_axi_rid;
  logic [1:0]              s_axi_rresp;
  logic                    s_axi_rlast;
  logic                    s_axi_rvalid;
  logic                    s_axi_rready;

  modport slave (
    input  s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    output s_axi_awready,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_bready,
    input  s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    output s_axi_arready,
    output s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    input  s_axi_rready
  );

  modport master (
    output s_axi_awaddr, s_axi_awid, s_axi_awlen, s_axi_awsize, s_axi_awburst, s_axi_awvalid,
    input  s_axi_awready,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_bready,
    output s_axi_araddr, s_axi_arid, s_axi_arlen, s_axi_arsize, s_axi_arburst, s_axi_arvalid,
    input  s_axi_arready,
    input  s_axi_rdata, s_axi_rid, s_axi_rresp, s_axi_rlast, s_axi_rvalid,
    output s_axi_rready
  );
endinterface

// File: rtl/cpu_csr_axi.sv
// AXI4 slave CSR file: 2^ADDR_WIDTH word-indexed registers behind independent write and read FSMs.
// All ready/valid outputs are registered copies of the next-state decode.
module cpu_csr_axi #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic         s_aclk,
  input  logic         s_aresetn,
  cpu_csr_axi_if.slave axi,
  output logic         rsta_busy,
  output logic         rstb_busy,
  output logic [1:0]   o_wstate_dbg,
  output logic         o_rstate_dbg
);
  localparam int NREG  = 1 << ADDR_WIDTH;
  localparam int NSTRB = DATA_WIDTH / 8;

  typedef enum logic [1:0] {W_ADDR = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;
  typedef enum logic       {R_ADDR = 1'b0, R_DATA = 1'b1} r_state_t;

  function automatic logic [ADDR_WIDTH-1:0] f_next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                        input logic [1:0] burst);
    return (burst == 2'b00) ? addr : addr + ADDR_WIDTH'(1);
  endfunction

  logic [DATA_WIDTH-1:0] r_regs [NREG];
  logic                  r_init;
  logic                  r_rsta_busy;
  logic                  r_rstb_busy;

  // Write-side state and registered outputs
  w_state_t              r_wstate;
  w_state_t              w_wnext;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [ADDR_WIDTH-1:0] r_awid;
  logic [7:0]            r_awlen;
  logic [1:0]            r_awburst;
  logic [7:0]            r_wcnt;
  logic                  r_awready;
  logic                  r_wready;
  logic                  r_bvalid;
  logic [ADDR_WIDTH-1:0] r_bid;
  logic                  w_awready_nxt;
  logic                  w_wready_nxt;
  logic                  w_bvalid_nxt;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic                  w_b_hs;

  // Read-side state and registered outputs
  r_state_t              r_rstate;
  r_state_t              w_rnext;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [1:0]            r_arburst;
  logic [7:0]            r_rcnt;
  logic                  r_arready;
  logic                  r_rvalid;
  logic                  r_rlast;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_rid;
  logic                  w_arready_nxt;
  logic                  w_rvalid_nxt;
  logic                  w_ar_hs;
  logic                  w_r_hs;
  logic                  w_rdone;
  logic [ADDR_WIDTH-1:0] w_rnext_addr;
  logic                  w_unused;

  assign w_aw_hs      = r_awready & axi.s_axi_awvalid;
  assign w_w_hs       = r_wready  & axi.s_axi_wvalid;
  assign w_b_hs       = r_bvalid  & axi.s_axi_bready;
  assign w_ar_hs      = r_arready & axi.s_axi_arvalid;
  assign w_r_hs       = r_rvalid  & axi.s_axi_rready;
  assign w_rdone      = (r_rcnt == r_arlen);
  assign w_rnext_addr = f_next_addr(r_araddr, r_arburst);

  // Size fields and wlast carry no information here: burst length alone ends a write.
  assign w_unused = ^{axi.s_axi_awsize, axi.s_axi_arsize, axi.s_axi_wlast};

  // Busy flags drop one cycle after the FSMs first report ready.
  always_ff @(posedge s_aclk) begin
    if (s_aresetn) begin
      r_init      <= 1'b1;
      r_rsta_busy <= 1'b1;
      r_rstb_busy <= 1'b1;
    end else begin
      r_init      <= 1'b0;
      r_rsta_busy <= r_init;
      r_rstb_busy <= r_init;
    end
  end

  always_ff @(posedge s_aclk) begin
    if (s_aresetn) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else if (w_w_hs) begin
      for (int b = 0; b < NSTRB; b++)
        if (axi.s_axi_wstrb[b]) r_regs[r_awaddr][8*b +: 8] <= axi.s_axi_wdata[8*b +: 8];
    end
  end

  // ---------------- write FSM ----------------
  always_ff @(posedge s_aclk) begin
    if (s_aresetn) begin
      r_wstate  <= W_ADDR;
      r_awaddr  <= '0;
      r_awid    <= '0;
      r_awlen   <= '0;
      r_awburst <= '0;
      r_wcnt    <= '0;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_bvalid  <= 1'b0;
      r_bid     <= '0;
    end else begin
      r_wstate  <= w_wnext;
      r_awready <= w_awready_nxt;
      r_wready  <= w_wready_nxt;
      r_bvalid  <= w_bvalid_nxt;
      if (w_aw_hs) begin
        r_awaddr  <= axi.s_axi_awaddr;
        r_awid    <= axi.s_axi_awid;
        r_awlen   <= axi.s_axi_awlen;
        r_awburst <= axi.s_axi_awburst;
        r_wcnt    <= '0;
      end else if (w_w_hs) begin
        r_awaddr <= f_next_addr(r_awaddr, r_awburst);
        r_wcnt   <= r_wcnt + 8'd1;
      end
      // bid only changes as the response is raised, so it holds while bvalid is low.
      if (w_w_hs && (w_wnext == W_RESP)) r_bid <= r_awid;
    end
  end

  always_comb begin
    w_wnext = r_wstate;
    case (r_wstate)
      W_ADDR:  if (w_aw_hs) w_wnext = W_DATA;
      W_DATA:  if (w_w_hs && (r_wcnt == r_awlen)) w_wnext = W_RESP;
      W_RESP:  if (w_b_hs) w_wnext = W_ADDR;
      default: w_wnext = W_ADDR;
    endcase
  end

  always_comb begin
    w_awready_nxt = (w_wnext == W_ADDR);
    w_wready_nxt  = (w_wnext == W_DATA);
    w_bvalid_nxt  = (w_wnext == W_RESP);
  end

  // ---------------- read FSM ----------------
  always_ff @(posedge s_aclk) begin
    if (s_aresetn) begin
      r_rstate  <= R_ADDR;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arburst <= '0;
      r_rcnt    <= '0;
      r_arready <= 1'b0;
      r_rvalid  <= 1'b0;
      r_rlast   <= 1'b0;
      r_rdata   <= '0;
      r_rid     <= '0;
    end else begin
      r_rstate  <= w_rnext;
      r_arready <= w_arready_nxt;
      r_rvalid  <= w_rvalid_nxt;
      if (w_ar_hs) begin
        r_araddr  <= axi.s_axi_araddr;
        r_arlen   <= axi.s_axi_arlen;
        r_arburst <= axi.s_axi_arburst;
        r_rcnt    <= '0;
        r_rid     <= axi.s_axi_arid;
        r_rdata   <= r_regs[axi.s_axi_araddr];
        r_rlast   <= (axi.s_axi_arlen == 8'd0);
      end else if (w_r_hs) begin
        if (w_rdone) begin
          r_rlast <= 1'b0;
        end else begin
          r_araddr <= w_rnext_addr;
          r_rcnt   <= r_rcnt + 8'd1;
          r_rdata  <= r_regs[w_rnext_addr];
          r_rlast  <= ((r_rcnt + 8'd1) == r_arlen);
        end
      end
    end
  end

  always_comb begin
    w_rnext = r_rstate;
    case (r_rstate)
      R_ADDR:  if (w_ar_hs) w_rnext = R_DATA;
      R_DATA:  if (w_r_hs && w_rdone) w_rnext = R_ADDR;
      default: w_rnext = R_ADDR;
    endcase
  end

  always_comb begin
    w_arready_nxt = (w_rnext == R_ADDR);
    w_rvalid_nxt  = (w_rnext == R_DATA);
  end

  assign axi.s_axi_awready = r_awready;
  assign axi.s_axi_wready  = r_wready;
  assign axi.s_axi_bvalid  = r_bvalid;
  assign axi.s_axi_bid     = r_bid;
  assign axi.s_axi_bresp   = 2'b00;
  assign axi.s_axi_arready = r_arready;
  assign axi.s_axi_rvalid  = r_rvalid;
  assign axi.s_axi_rlast   = r_rlast;
  assign axi.s_axi_rdata   = r_rdata;
  assign axi.s_axi_rid     = r_rid;
  assign axi.s_axi_rresp   = 2'b00;
  assign rsta_busy         = r_rsta_busy;
  assign rstb_busy         = r_rstb_busy;
  assign o_wstate_dbg      = r_wstate;
  assign o_rstate_dbg      = r_rstate;
endmodule

// File: tb/tb_cpu_csr_axi.sv
// Bench for cpu_csr_axi: a vector table, hand-written burst/back-pressure/reset sequences,
// and random traffic checked against a word-array model of the register file.
module tb_cpu_csr_axi;
  localparam int TMO = 20;

  logic       clk;
  logic       rst;
  logic       rsta_busy;
  logic       rstb_busy;
  logic [1:0] wstate_dbg;
  logic       rstate_dbg;

  cpu_csr_axi_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  cpu_csr_axi #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .s_aclk       (clk),
    .s_aresetn    (rst),
    .axi          (bus),
    .rsta_busy    (rsta_busy),
    .rstb_busy    (rstb_busy),
    .o_wstate_dbg (wstate_dbg),
    .o_rstate_dbg (rstate_dbg)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- model and scoreboard ----------------
  logic [31:0] model_mem [32];
  logic [31:0] exp_q [$];
  logic [31:0] wb_data [16];
  logic [3:0]  wb_strb [16];
  int          n_checks;
  int          n_fail;

  typedef struct {
    logic [4:0]  addr;
    logic [4:0]  id;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Address of beat i computed from the burst rules: FIXED holds, all others step modulo 32.
  function automatic logic [4:0] beat_addr(input logic [4:0] addr, input logic [1:0] burst, input int i);
    return (burst == 2'b00) ? addr : 5'((int'(addr) + i) % 32);
  endfunction

  // ---------------- driver tasks (enter and leave on a falling edge) ----------------
  task automatic do_write(input logic [4:0] addr, input logic [4:0] id, input logic [7:0] len,
                          input logic [1:0] burst, input int b_hold);
    int t;
    logic [4:0] a;
    bus.s_axi_awaddr  = addr;
    bus.s_axi_awid    = id;
    bus.s_axi_awlen   = len;
    bus.s_axi_awburst = burst;
    bus.s_axi_awsize  = 3'd2;
    bus.s_axi_awvalid = 1'b1;
    t = 0;
    while (bus.s_axi_awready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    check("aw_wait", 32'(t < TMO), 32'd1);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
    check("w_after_aw", 32'(bus.s_axi_wready), 32'd1);
    check("aw_busy", 32'(bus.s_axi_awready), 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      bus.s_axi_wdata  = wb_data[i];
      bus.s_axi_wstrb  = wb_strb[i];
      bus.s_axi_wlast  = (i == int'(len));
      bus.s_axi_wvalid = 1'b1;
      t = 0;
      while (bus.s_axi_wready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
      check("w_wait", 32'(t < TMO), 32'd1);
      @(negedge clk);
      a = beat_addr(addr, burst, i);
      for (int b = 0; b < 4; b++)
        if (wb_strb[i][b]) model_mem[a][8*b +: 8] = wb_data[i][8*b +: 8];
    end
    bus.s_axi_wvalid = 1'b0;
    bus.s_axi_wlast  = 1'b0;
    check("b_after_w", 32'(bus.s_axi_bvalid), 32'd1);
    check("bid", 32'(bus.s_axi_bid), 32'(id));
    check("bresp", 32'(bus.s_axi_bresp), 32'd0);
    for (int k = 0; k < b_hold; k++) begin
      @(negedge clk);
      check("b_hold_valid", 32'(bus.s_axi_bvalid), 32'd1);
      check("b_hold_awready", 32'(bus.s_axi_awready), 32'd0);
    end
    bus.s_axi_bready = 1'b1;
    @(negedge clk);
    bus.s_axi_bready = 1'b0;
    check("aw_after_b", 32'(bus.s_axi_awready), 32'd1);
    check("b_dropped", 32'(bus.s_axi_bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [4:0] addr, input logic [4:0] id, input logic [7:0] len,
                         input logic [1:0] burst, input int r_hold, output logic [31:0] last_data);
    int t;
    logic [31:0] exp;
    for (int i = 0; i <= int'(len); i++) exp_q.push_back(model_mem[beat_addr(addr, burst, i)]);
    last_data = '0;
    bus.s_axi_araddr  = addr;
    bus.s_axi_arid    = id;
    bus.s_axi_arlen   = len;
    bus.s_axi_arburst = burst;
    bus.s_axi_arsize  = 3'd2;
    bus.s_axi_arvalid = 1'b1;
    t = 0;
    while (bus.s_axi_arready !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
    check("ar_wait", 32'(t < TMO), 32'd1);
    @(negedge clk);
    bus.s_axi_arvalid = 1'b0;
    check("r_after_ar", 32'(bus.s_axi_rvalid), 32'd1);
    check("ar_busy", 32'(bus.s_axi_arready), 32'd0);
    for (int i = 0; i <= int'(len); i++) begin
      t = 0;
      while (bus.s_axi_rvalid !== 1'b1 && t < TMO) begin @(negedge clk); t++; end
      check("r_wait", 32'(t < TMO), 32'd1);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
      check("rdata", bus.s_axi_rdata, exp);
      check("rid", 32'(bus.s_axi_rid), 32'(id));
      check("rresp", 32'(bus.s_axi_rresp), 32'd0);
      check("rlast", 32'(bus.s_axi_rlast), 32'(i == int'(len)));
      if (i == 0) begin
        for (int k = 0; k < r_hold; k++) begin
          @(negedge clk);
          check("r_hold_valid", 32'(bus.s_axi_rvalid), 32'd1);
          check("r_hold_data", bus.s_axi_rdata, exp);
        end
      end
      last_data = bus.s_axi_rdata;
      bus.s_axi_rready = 1'b1;
      @(negedge clk);
      bus.s_axi_rready = 1'b0;
    end
    check("ar_after_r", 32'(bus.s_axi_arready), 32'd1);
    check("r_dropped", 32'(bus.s_axi_rvalid), 32'd0);
  endtask

  task automatic reset_and_check();
    rst = 1'b1;
    for (int i = 0; i < 32; i++) model_mem[i] = '0;
    exp_q.delete();
    bus.s_axi_awvalid = 1'b0; bus.s_axi_wvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    bus.s_axi_bready  = 1'b0; bus.s_axi_rready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_awready", 32'(bus.s_axi_awready), 32'd0);
    check("rst_arready", 32'(bus.s_axi_arready), 32'd0);
    check("rst_wready", 32'(bus.s_axi_wready), 32'd0);
    check("rst_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.s_axi_rvalid), 32'd0);
    check("rst_rlast", 32'(bus.s_axi_rlast), 32'd0);
    check("rst_rdata", bus.s_axi_rdata, 32'd0);
    check("rst_ids", 32'({bus.s_axi_rid, bus.s_axi_bid}), 32'd0);
    check("rst_busy", 32'({rsta_busy, rstb_busy}), 32'd3);
    rst = 1'b0;
    @(negedge clk);
    check("rel_awready", 32'(bus.s_axi_awready), 32'd1);
    check("rel_arready", 32'(bus.s_axi_arready), 32'd1);
    check("rel_busy_hold", 32'({rsta_busy, rstb_busy}), 32'd3);
    check("rel_no_bvalid", 32'(bus.s_axi_bvalid), 32'd0);
    @(negedge clk);
    check("rel_busy_clear", 32'({rsta_busy, rstb_busy}), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] got;
    logic [4:0]  r_addr;
    logic [4:0]  r_id;
    logic [7:0]  r_len;
    logic [1:0]  r_burst;
    n_checks = 0;
    n_fail   = 0;
    vecs[0] = '{5'd0, 5'd3,  32'hA5A5A5A5, 4'hF, 32'hA5A5A5A5};
    vecs[1] = '{5'd1, 5'd4,  32'hA5A5A5A6, 4'hF, 32'hA5A5A5A6};
    vecs[2] = '{5'd2, 5'd5,  32'hA5A5A5A7, 4'hF, 32'hA5A5A5A7};
    vecs[3] = '{5'd3, 5'd6,  32'hA5A5A5A8, 4'hF, 32'hA5A5A5A8};
    vecs[4] = '{5'd4, 5'd7,  32'hA5A5A5A9, 4'hF, 32'hA5A5A5A9};
    vecs[5] = '{5'd7, 5'd8,  32'hFFFFFFFF, 4'hF, 32'hFFFFFFFF};
    vecs[6] = '{5'd7, 5'd9,  32'h12345678, 4'b0101, 32'hFF34FF78};
    vecs[7] = '{5'd9, 5'd10, 32'hDEADBEEF, 4'b1000, 32'hDE000000};
    vecs[8] = '{5'd9, 5'd31, 32'hCAFEF00D, 4'b0010, 32'hDE00F000};

    bus.s_axi_awaddr = '0; bus.s_axi_awid = '0; bus.s_axi_awlen = '0; bus.s_axi_awsize = '0;
    bus.s_axi_awburst = '0; bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_araddr = '0; bus.s_axi_arid = '0; bus.s_axi_arlen = '0; bus.s_axi_arsize = '0;
    bus.s_axi_arburst = '0; bus.s_axi_arvalid = 1'b0; bus.s_axi_rready = 1'b0;

    reset_and_check();

    // Single-beat vectors with strobes
    for (int i = 0; i < 9; i++) begin
      wb_data[0] = vecs[i].wdata;
      wb_strb[0] = vecs[i].strb;
      do_write(vecs[i].addr, vecs[i].id, 8'd0, 2'b01, 0);
      do_read(vecs[i].addr, vecs[i].id ^ 5'h15, 8'd0, 2'b01, 0, got);
      check("vec_rdata", got, vecs[i].exp);
    end

    // INCR burst wrapping 30 -> 1
    for (int i = 0; i < 4; i++) begin wb_data[i] = 32'(i + 1); wb_strb[i] = 4'hF; end
    do_write(5'd30, 5'd11, 8'd3, 2'b01, 0);
    do_read(5'd30, 5'd12, 8'd3, 2'b01, 0, got);
    check("incr_last_beat", got, 32'd4);
    do_read(5'd0, 5'd13, 8'd0, 2'b01, 0, got);
    check("incr_reg0", got, 32'd3);
    do_read(5'd31, 5'd14, 8'd0, 2'b01, 0, got);
    check("incr_reg31", got, 32'd2);

    // WRAP type steps like INCR
    wb_data[0] = 32'h11; wb_data[1] = 32'h22; wb_strb[0] = 4'hF; wb_strb[1] = 4'hF;
    do_write(5'd31, 5'd15, 8'd1, 2'b10, 0);
    do_read(5'd0, 5'd16, 8'd0, 2'b01, 0, got);
    check("wrap_reg0", got, 32'h22);

    // FIXED burst: every beat lands on the same register
    wb_data[0] = 32'hAA; wb_data[1] = 32'hBB; wb_data[2] = 32'hCC;
    for (int i = 0; i < 3; i++) wb_strb[i] = 4'hF;
    do_write(5'd12, 5'd17, 8'd2, 2'b00, 0);
    do_read(5'd12, 5'd18, 8'd1, 2'b00, 0, got);
    check("fixed_reg12", got, 32'hCC);

    // Back-pressure on B and R
    wb_data[0] = 32'h600DF00D; wb_strb[0] = 4'hF;
    do_write(5'd5, 5'd21, 8'd0, 2'b01, 5);
    do_read(5'd5, 5'd22, 8'd0, 2'b01, 4, got);
    check("bp_reg5", got, 32'h600DF00D);

    // Reset in the middle of a 2-beat write, then every register must read 0
    bus.s_axi_awaddr = 5'd10; bus.s_axi_awid = 5'd1; bus.s_axi_awlen = 8'd1;
    bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b1;
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = 32'h0BAD0BAD; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
    @(negedge clk);
    bus.s_axi_wvalid = 1'b0;
    check("abort_mid_burst", 32'(bus.s_axi_wready), 32'd1);
    reset_and_check();
    for (int a = 0; a < 32; a++) begin
      do_read(5'(a), 5'(a), 8'd0, 2'b01, 0, got);
      check("reset_clear", got, 32'd0);
    end

    // Simultaneous AR and AW to register 2: the read sees the old value
    bus.s_axi_awaddr = 5'd2; bus.s_axi_awid = 5'd3; bus.s_axi_awlen = 8'd0;
    bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b1;
    bus.s_axi_araddr = 5'd2; bus.s_axi_arid = 5'd4; bus.s_axi_arlen = 8'd0;
    bus.s_axi_arburst = 2'b01; bus.s_axi_arvalid = 1'b1;
    check("sim_readies", 32'({bus.s_axi_awready, bus.s_axi_arready}), 32'd3);
    @(negedge clk);
    bus.s_axi_awvalid = 1'b0; bus.s_axi_arvalid = 1'b0;
    check("sim_rvalid", 32'(bus.s_axi_rvalid), 32'd1);
    check("sim_wready", 32'(bus.s_axi_wready), 32'd1);
    bus.s_axi_wdata = 32'h55; bus.s_axi_wstrb = 4'hF; bus.s_axi_wlast = 1'b1; bus.s_axi_wvalid = 1'b1;
    bus.s_axi_rready = 1'b1; bus.s_axi_bready = 1'b1;
    @(negedge clk);
    check("sim_old_value", bus.s_axi_rdata, 32'd0);
    bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0; bus.s_axi_rready = 1'b0;
    check("sim_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
    check("sim_bid", 32'(bus.s_axi_bid), 32'd3);
    @(negedge clk);
    bus.s_axi_bready = 1'b0;
    model_mem[2] = 32'h55;
    do_read(5'd2, 5'd9, 8'd0, 2'b01, 0, got);
    check("sim_new_value", got, 32'h55);

    // Random traffic against the model
    for (int n = 0; n < 60; n++) begin
      r_addr  = 5'($urandom_range(0, 31));
      r_id    = 5'($urandom_range(0, 31));
      r_len   = 8'($urandom_range(0, 3));
      r_burst = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i < 4; i++) begin
          wb_data[i] = $urandom;
          wb_strb[i] = 4'($urandom_range(0, 15));
        end
        do_write(r_addr, r_id, r_len, r_burst, int'($urandom_range(0, 2)));
      end else begin
        do_read(r_addr, r_id, r_len, r_burst, int'($urandom_range(0, 2)), got);
      end
    end
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/cpu_csr_axi.md
# cpu_csr_axi

AXI4 slave register file of 32 × 32-bit control/status registers for the CPU subsystem. Reads and writes go through independent read and write channel state machines. Each AXI address value selects one whole 32-bit register (word index, not byte address). The block sits on the CPU interconnect as the CSR target.

## Interface
- ADDR_WIDTH, 5, address and ID width; register count = 2^ADDR_WIDTH
- DATA_WIDTH, 32, register and data-bus width; strobe width = DATA_WIDTH/8
- s_aclk  in  1  single clock, all logic on rising edge
- s_aresetn  in  1  reset, synchronous, active-high (1 = reset asserted)
- s_axi_awaddr / s_axi_awid  in  ADDR_WIDTH  write word index / write ID
- s_axi_awlen  in  8  burst beats minus 1
- s_axi_awsize  in  3  ignored
- s_axi_awburst  in  2  burst type
- s_axi_awvalid  in  1 / s_axi_awready  out  1  write-address handshake
- s_axi_wdata  in  DATA_WIDTH / s_axi_wstrb  in  4 / s_axi_wlast  in  1  write data, byte enables, last flag
- s_axi_wvalid  in  1 / s_axi_wready  out  1  write-data handshake
- s_axi_bid  out  ADDR_WIDTH / s_axi_bresp  out  2  write response
- s_axi_bvalid  out  1 / s_axi_bready  in  1  write-response handshake
- s_axi_araddr / s_axi_arid  in  ADDR_WIDTH / s_axi_arlen  in  8 / s_axi_arsize  in  3 (ignored) / s_axi_arburst  in  2  read address
- s_axi_arvalid  in  1 / s_axi_arready  out  1  read-address handshake
- s_axi_rdata  out  DATA_WIDTH / s_axi_rid  out  ADDR_WIDTH / s_axi_rresp  out  2 / s_axi_rlast  out  1  read data
- s_axi_rvalid  out  1 / s_axi_rready  in  1  read-data handshake
- rsta_busy / rstb_busy  out  1  write-side / read-side busy-after-reset flags

## Operation
- Storage: 32 registers, all cleared to 0 on reset.
- Write FSM states: W_ADDR, W_DATA, W_RESP.
  - W_ADDR: awready=1. On awvalid, capture awaddr, awid and awlen, clear the beat counter, go to W_DATA.
  - W_DATA: wready=1. On each wvalid beat, write every byte lane whose wstrb bit is 1 into reg[addr]; lanes with strobe 0 keep their value.
  - The beat on which counter == awlen ends the burst and moves to W_RESP. wlast is ignored for termination.
  - W_RESP: bvalid=1, bid = captured awid, bresp=2'b00. Hold until bready, then go to W_ADDR.
- Read FSM states: R_ADDR, R_DATA.
  - R_ADDR: arready=1. On arvalid, capture arid and arlen, latch rdata ← reg[araddr], go to R_DATA.
  - R_DATA: rvalid=1, rid = captured arid, rresp=2'b00, rlast = (counter == arlen). rdata is held stable while rready=0.
  - On rready: if it was the last beat, return to R_ADDR; otherwise advance the address and load the next word.
- Burst addressing:
  - FIXED (2'b00): address does not change.
  - INCR (2'b01) and WRAP/reserved: address increments by 1 and wraps modulo 32 (31 → 0).
- Response codes: all accesses return OKAY (2'b00). There is no error decoding.
- Concurrency: read and write FSMs are fully independent. A read sampling the same register in the same cycle as a write returns the old value.
- rdata, rid and bid keep their last values when the corresponding valid is low.

## Timing
- Reset (s_aresetn=1) values: awready, wready, bvalid, arready, rvalid, rlast = 0; bresp, rresp = 0; rdata, rid, bid = 0; rsta_busy, rstb_busy = 1.
- First cycle after reset release: awready=1, arready=1; busy flags go 0 one cycle later.
- Reset asserted mid-transaction: the transaction is aborted, both FSMs return to idle, registers clear. No response is issued.
- All ready/valid outputs are registered.
- Write latency:
  - AW handshake at edge N → wready=1 from N+1.
  - Final W handshake at edge M → bvalid=1 from M+1.
  - B handshake at edge K → awready=1 from K+1.
- Read latency:
  - AR handshake at edge N → rvalid=1 with valid rdata from N+1.
  - Each R handshake advances one beat per cycle.
  - Final R handshake at edge K → arready=1 from K+1.
- Only one outstanding transaction per direction; awready and arready are 0 while their FSM is busy.

## Test plan
- Write 0xA5A5A5A5+a to addresses a=0..4 (len 0, strb 4'hF), then read each → rdata matches, bresp=rresp=0, rlast=1, bid/rid equal the issued IDs.
- Reset check → all registers read 0; awready/arready =0 during reset, =1 one cycle after release; busy flags 1 then 0.
- Write 0xFFFFFFFF to address 7, then 0x12345678 with wstrb=4'b0101 → read returns 0xFF34FF78.
- INCR write burst awlen=3 at address 30 with data 1,2,3,4 → registers 30, 31, 0, 1 hold 1, 2, 3, 4; a 4-beat INCR read from address 30 returns the same, with rlast only on beat 4.
- Back-pressure: hold bready=0 for 5 cycles → bvalid stays 1 and awready stays 0; hold rready=0 → rvalid and rdata stay stable.
- Simultaneous AR and AW to address 2 in the same cycle (old value 0, new value 0x55) → read returns 0, a later read returns 0x55.
